// File: rtl/multiplication.sv
// Sequential radix-2 shift-add multiplier, unsigned or two's-complement signed.
// One partial product per cycle; start/busy/done handshake matches the divider.
module multiplication #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b;

  // The most negative value's magnitude still fits in WIDTH unsigned bits.
  always_comb begin
    abs_a = (sgn && A[WIDTH-1]) ? -A : A;
    abs_b = (sgn && B[WIDTH-1]) ? -B : B;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    p_d      = p_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          neg_d    = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == CntLast) begin
          p_d     = neg_q ? -acc_q : acc_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          // mcand_q tracks mag_a << cnt, so no barrel shifter is needed.
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      p_q      <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      p_q      <= p_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for the shift-add multiplier: handshake timing, signed/unsigned
// products, corner operands and mid-operation reset.
module tb_multiplication;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [63:0] P;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  multiplication #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Issue one operation, scramble inputs after accept, observe 45 cycles.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p_got, output int busy_cnt,
                        output int done_cnt, output int done_at);
    @(negedge clk);
    sgn = s; A = a; B = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; sgn = ~s; A = ~a; B = a ^ b;
    busy_cnt = 0; done_cnt = 0; done_at = -1; p_got = 'x;
    for (int k = 0; k < 45; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          p_got = P;
        end
      end
    end
  endtask

  task automatic test_reset();
    int dn;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (P !== 64'd0) begin errors++; $display("FAIL reset_p got %h want 0", P); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL reset_idle_done got %0d want 0", dn); end
    checks++; if (P !== 64'd0) begin errors++; $display("FAIL reset_idle_p got %h want 0", P); end
  endtask

  task automatic test_unsigned_small();
    logic [63:0] p; int bc, dc, da;
    run_op(1'b0, 32'd100, 32'd3, p, bc, dc, da);
    checks++; if (p !== 64'd300) begin errors++; $display("FAIL u_small_p got %h want %h", p, 64'd300); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL u_small_busy_cycles got %0d want 33", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL u_small_done_pulses got %0d want 1", dc); end
    checks++; if (da !== 33) begin errors++; $display("FAIL u_small_latency got %0d want 33", da); end
    checks++; if (P !== 64'd300) begin errors++; $display("FAIL u_small_hold got %h want %h", P, 64'd300); end
  endtask

  task automatic test_unsigned_max();
    logic [63:0] p; int bc, dc, da;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, bc, dc, da);
    checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL u_max_p got %h want FFFFFFFE00000001", p); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL u_max_done_pulses got %0d want 1", dc); end
    run_op(1'b0, 32'h8000_0000, 32'd2, p, bc, dc, da);
    checks++; if (p !== 64'h0000_0001_0000_0000) begin
      errors++; $display("FAIL u_msb_p got %h want 0000000100000000", p); end
  endtask

  task automatic test_signed();
    logic [63:0] p; int bc, dc, da;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd6, p, bc, dc, da);
    checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      errors++; $display("FAIL s_neg_p got %h want FFFFFFFFFFFFFFD6", p); end
    checks++; if (da !== 33) begin errors++; $display("FAIL s_neg_latency got %0d want 33", da); end
    run_op(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, p, bc, dc, da);
    checks++; if (p !== 64'd12) begin errors++; $display("FAIL s_negneg_p got %h want %h", p, 64'd12); end
  endtask

  task automatic test_signed_min_and_zero();
    logic [63:0] p; int bc, dc, da;
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, p, bc, dc, da);
    checks++; if (p !== 64'h4000_0000_0000_0000) begin
      errors++; $display("FAIL s_min_p got %h want 4000000000000000", p); end
    run_op(1'b1, 32'd0, 32'hFFFF_FFFB, p, bc, dc, da);
    checks++; if (p !== 64'd0) begin errors++; $display("FAIL s_zero_p got %h want 0", p); end
    checks++; if (da !== 33) begin errors++; $display("FAIL s_zero_latency got %0d want 33", da); end
  endtask

  task automatic test_abort_and_hold();
    logic [63:0] p; int bc, dc, da, dn, bad;
    dn = 0;
    @(negedge clk);
    sgn = 1'b0; A = 32'd50; B = 32'd5; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn++;
      if (c == 10) begin A = 32'd9; B = 32'd9; start = 1'b1; end
      if (c == 20) rst = 1'b0;
    end
    #1;
    checks++; if (P !== 64'd0) begin errors++; $display("FAIL abort_p got %h want 0", P); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dn); end
    checks++; if (P !== 64'd0) begin errors++; $display("FAIL abort_p_after got %h want 0", P); end
    run_op(1'b0, 32'd50, 32'd5, p, bc, dc, da);
    checks++; if (p !== 64'd250) begin errors++; $display("FAIL rerun_p got %h want %h", p, 64'd250); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL rerun_done_pulses got %0d want 1", dc); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (P !== 64'd250 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_hold got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_unsigned_small();
    test_unsigned_max();
    test_signed();
    test_signed_min_and_zero();
    test_abort_and_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
